// File: rtl/pdm_tx_modulator.sv
// First-order delta-sigma PDM transmitter: divides clk down to pdm_clk and
// modulates one buffered signed PCM sample per OSR PDM bits.
module pdm_tx_modulator #(
  parameter int CLK_DIV = 50,
  parameter int OSR     = 64,
  parameter int DATA_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     pdm_clk,
  output logic                     pdm_out,
  output logic                     underrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(OSR);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(OSR - 1);
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_cur;
  logic [DATA_W-1:0] r_nxt;
  logic              r_nxt_full;
  logic [DATA_W-1:0] r_acc;
  logic              r_in_ready;
  logic              r_pdm_clk;
  logic              r_pdm_out;
  logic              r_underrun;

  logic              w_rise;
  logic              w_fall;
  logic              w_boundary;
  logic              w_accept;
  logic              w_nxt_full_next;
  logic [DATA_W-1:0] w_u;
  logic [DATA_W:0]   w_sum;

  assign w_rise     = (r_div_cnt == DIV_LAST);
  assign w_fall     = (r_div_cnt == DIV_HALF);
  assign w_boundary = w_fall && (r_bit_cnt == BIT_LAST);
  assign w_accept   = in_valid && r_in_ready;

  // Flipping the sign bit maps two's complement onto the 0..2^DATA_W-1 offset form.
  assign w_u   = r_cur ^ MSB_MASK;
  assign w_sum = {1'b0, r_acc} + {1'b0, w_u};

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    w_nxt_full_next = r_nxt_full;
    if (w_accept) begin
      w_nxt_full_next = 1'b1;
    end else if (w_boundary) begin
      w_nxt_full_next = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_cur      <= '0;
      r_nxt      <= '0;
      r_nxt_full <= 1'b0;
      r_acc      <= '0;
      r_in_ready <= 1'b0;
      r_pdm_clk  <= 1'b0;
      r_pdm_out  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_div_cnt  <= w_rise ? '0 : r_div_cnt + DIV_W'(1);
      r_underrun <= 1'b0;

      if (w_rise) begin
        r_pdm_clk <= 1'b1;
      end else if (w_fall) begin
        r_pdm_clk <= 1'b0;
      end

      if (w_fall) begin
        r_pdm_out <= w_sum[DATA_W];
        r_acc     <= w_sum[DATA_W-1:0];
        r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + BIT_W'(1);
      end

      // The last bit of a period still used the old sample; swap it in now.
      if (w_boundary) begin
        if (r_nxt_full) begin
          r_cur <= r_nxt;
        end else begin
          r_cur      <= '0;
          r_underrun <= 1'b1;
        end
      end

      if (w_accept) begin
        r_nxt <= in_data;
      end

      r_nxt_full <= w_nxt_full_next;
      r_in_ready <= ~w_nxt_full_next;
    end
  end

  assign in_ready = r_in_ready;
  assign pdm_clk  = r_pdm_clk;
  assign pdm_out  = r_pdm_out;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_pdm_tx_modulator.sv
// Self-checking bench for pdm_tx_modulator: table vectors, idle, handshake,
// random traffic against an arithmetic reference, async reset and loopback.
module tb_pdm_tx_modulator;

  localparam int CD = 4;
  localparam int OS = 8;
  localparam int DW = 8;
  localparam int PERIOD = CD * OS;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic signed [7:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              pdm_clk;
  logic              pdm_out;
  logic              underrun;

  logic              lb_rst_n = 1'b0;
  logic              lb_ready;
  logic              lb_pclk;
  logic              lb_pout;
  logic              lb_und;

  always #5 clk = ~clk;

  pdm_tx_modulator #(.CLK_DIV(CD), .OSR(OS), .DATA_W(DW)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pdm_clk  (pdm_clk),
    .pdm_out  (pdm_out),
    .underrun (underrun)
  );

  pdm_tx_modulator #(.CLK_DIV(50), .OSR(64), .DATA_W(8)) u_dut_lb (
    .clk      (clk),
    .reset_n  (lb_rst_n),
    .in_data  (8'sd64),
    .in_valid (1'b1),
    .in_ready (lb_ready),
    .pdm_clk  (lb_pclk),
    .pdm_out  (lb_pout),
    .underrun (lb_und)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver side: capture each PDM bit on the rising edge of pdm_clk.
  int rx_q[$];
  always @(posedge pdm_clk) if (reset_n) rx_q.push_back(int'(pdm_out));

  // Loopback decimator: count ones over each 64-bit window.
  int lb_win[$];
  int lb_ones = 0;
  int lb_bits = 0;
  always @(posedge lb_pclk) begin
    lb_ones += int'(lb_pout);
    lb_bits++;
    if (lb_bits == 64) begin
      lb_win.push_back(lb_ones);
      lb_ones = 0;
      lb_bits = 0;
    end
  end

  initial begin
    #12 lb_rst_n = 1'b1;
  end

  // Reference model: edge index since release, fall/rise events derived from it.
  int m_n, m_cur, m_acc, m_bitk;
  bit m_ready, m_pclk, m_pout, m_und;
  int m_q[$];
  bit dut_acc;
  bit model_acc;

  function automatic void model_reset();
    m_n = 0; m_cur = 0; m_acc = 0; m_bitk = 0;
    m_ready = 0; m_pclk = 0; m_pout = 0; m_und = 0;
    m_q.delete();
  endfunction

  function automatic bit model_edge(input bit v, input int d);
    bit acc_ok;
    int s;
    acc_ok = v && m_ready;
    m_n++;
    m_und = 0;
    if (m_n % CD == CD / 2) begin
      s = m_acc + m_cur + 2 ** (DW - 1);
      m_pout = (s >= 2 ** DW);
      m_acc = s % (2 ** DW);
      m_pclk = 0;
      if (m_bitk == OS - 1) begin
        m_bitk = 0;
        if (m_q.size() > 0) m_cur = m_q.pop_front();
        else begin
          m_cur = 0;
          m_und = 1;
        end
      end else begin
        m_bitk++;
      end
    end
    if (m_n % CD == 0) m_pclk = 1;
    if (acc_ok) m_q.push_back(d);
    m_ready = (m_q.size() == 0);
    return acc_ok;
  endfunction

  task automatic step(input bit v, input int d);
    in_valid = v;
    in_data  = d[7:0];
    dut_acc  = v && in_ready;
    @(posedge clk);
    model_acc = model_edge(v, d);
    #1;
    check("pdm_clk", pdm_clk, m_pclk);
    check("pdm_out", pdm_out, m_pout);
    check("in_ready", in_ready, m_ready);
    check("underrun", underrun, m_und);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pdm_clk", pdm_clk, 0);
    check("rst_pdm_out", pdm_out, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_underrun", underrun, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rx_q.delete();
  endtask

  typedef struct {
    int         sample;
    logic [0:7] bits;
    int         ones;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int und_cnt, rise_cnt, acc_idx, last_edge, k, guard;
    bit prev_pclk;
    logic [0:7] got;

    vecs[0] = '{sample:   64, bits: 8'b0111_0111, ones: 6};
    vecs[1] = '{sample:    0, bits: 8'b0101_0101, ones: 4};
    vecs[2] = '{sample:  127, bits: 8'b0111_1111, ones: 7};
    vecs[3] = '{sample: -128, bits: 8'b0000_0000, ones: 0};
    vecs[4] = '{sample:  -64, bits: 8'b0001_0001, ones: 2};
    vecs[5] = '{sample:    1, bits: 8'b0101_0101, ones: 4};
    vecs[6] = '{sample:   96, bits: 8'b0111_1111, ones: 7};

    // Table: each sample is loaded at the first boundary, where acc is back at 0.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      step(0, 0);
      step(1, vecs[i].sample);
      guard = 0;
      while (rx_q.size() < 16 && guard < 200) begin
        step(0, 0);
        guard++;
      end
      check("vec_rx_timeout", rx_q.size() >= 16, 1);
      if (rx_q.size() >= 16) begin
        for (int b = 0; b < 8; b++) got[b] = rx_q[8 + b][0];
        check($sformatf("vec%0d_bits", i), got, vecs[i].bits);
        check($sformatf("vec%0d_ones", i), $countones(got), vecs[i].ones);
      end
    end

    // Idle: pdm_clk period CD, underrun every OS fall events.
    do_reset();
    und_cnt = 0;
    rise_cnt = 0;
    prev_pclk = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 0);
      if (underrun) und_cnt++;
      if (pdm_clk && !prev_pclk) rise_cnt++;
      prev_pclk = pdm_clk;
    end
    check("idle_underruns", und_cnt, 3);
    check("idle_pclk_rises", rise_cnt, 100 / CD);

    // Handshake: valid held high, data increments per accept.
    do_reset();
    k = 0;
    acc_idx = 0;
    last_edge = 0;
    for (int i = 0; i < 8 * PERIOD; i++) begin
      step(1, k);
      if (dut_acc) begin
        if (acc_idx >= 2) check("accept_interval", m_n - last_edge, PERIOD);
        last_edge = m_n;
        acc_idx++;
      end
      if (model_acc) k++;
    end
    check("accept_count", acc_idx, k);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0)
        step($urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? 127 : -128);
      else
        step($urandom_range(0, 2) != 0, int'($urandom_range(0, 255)) - 128);
    end

    // Asynchronous reset with a sample buffered; it must never be emitted.
    do_reset();
    step(0, 0);
    step(1, 100);
    repeat (3) step(0, 0);
    check("pre_rst_buffered", in_ready, 0);
    #1 reset_n = 1'b0;
    #1;
    check("async_pdm_clk", pdm_clk, 0);
    check("async_pdm_out", pdm_out, 0);
    check("async_in_ready", in_ready, 0);
    check("async_underrun", underrun, 0);
    do_reset();
    for (int i = 0; i < 3 * PERIOD + 4; i++) step(0, 0);

    // Loopback at default parameters: density of constant 64 is 48/64.
    guard = 0;
    while (lb_win.size() < 4 && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    check("lb_timeout", lb_win.size() >= 4, 1);
    if (lb_win.size() >= 4) begin
      check("lb_win2", lb_win[2], 48);
      check("lb_win3", lb_win[3], 48);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_tx_modulator.md
# pdm_tx_modulator

Converts a stream of signed PCM samples back into a 1-bit PDM bitstream with a first-order delta-sigma (phase-accumulator) modulator. It generates the PDM bit clock itself from the 100 MHz system clock. It sits at the output end of the audio path and is the transmit-side counterpart of the PDM mic capture/decimation chain. It drives a PDM DAC or amplifier, or feeds the capture chain in loopback: bits change on the falling edge of `pdm_clk`, so a receiver sampling on the rising edge sees a stable bit.

## Interface
- `CLK_DIV`, 50: system clocks per PDM bit. Must be even and ≥4. Default gives 2 MHz from 100 MHz.
- `OSR`, 64: PDM bits per PCM sample. Must be ≥2.
- `DATA_W`, 8: PCM sample width, two's complement.
- `clk` in 1: system clock, 100 MHz. This is the only clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_data` in DATA_W: signed PCM sample.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: registered; the block can accept a sample.
- `pdm_clk` out 1: registered PDM bit clock, 50% duty.
- `pdm_out` out 1: registered PDM data. 1 = +full scale.
- `underrun` out 1: one-`clk` pulse when a sample period starts with no buffered sample.

## Operation
- **Divider.** `div_cnt` runs 0..CLK_DIV-1 and wraps. Reset value 0.
  - Rise event: the edge where `div_cnt` wraps from CLK_DIV-1 to 0 sets `pdm_clk` to 1.
  - Fall event: the edge where `div_cnt` goes from CLK_DIV/2-1 to CLK_DIV/2 clears `pdm_clk` to 0.
- **Buffering.** Two registers.
  - `cur`: the sample being modulated. Reset value 0, which is mid-scale silence.
  - `nxt` with flag `nxt_full`: a one-deep input buffer. Reset value empty.
- **Handshake.** `in_ready` = ~`nxt_full`, registered, and 0 while in reset.
  - An accept occurs on any edge with `in_valid` & `in_ready`. It loads `nxt`, sets `nxt_full`, and `in_ready` reads 0 from the next cycle.
  - `in_data` is ignored when there is no accept.
- **Modulator.** It runs once per fall event.
  - u = `cur` + 2^(DATA_W-1), the unsigned offset form (0..2^DATA_W-1).
  - sum = `acc` + u, DATA_W+1 bits wide.
  - `pdm_out` <= sum[DATA_W].
  - `acc` <= sum[DATA_W-1:0].
  - `acc` is DATA_W bits, resets to 0, and is never cleared on sample change.
  - Resulting ones density is u/2^DATA_W: -2^(DATA_W-1) gives all zeros; 2^(DATA_W-1)-1 gives (2^DATA_W-1)/2^DATA_W.
- **Sample boundary.** `bit_cnt` counts fall events 0..OSR-1. Reset value 0.
  - On the fall event where `bit_cnt` = OSR-1, that bit still uses the old `cur`, and on the same edge:
    - if `nxt_full`: `cur` <= `nxt`, `nxt_full` <= 0, and `in_ready` reads 1 from the next cycle;
    - else: `cur` <= 0 and `underrun` pulses for that one cycle.
  - An accept cannot collide with a boundary load, because `in_ready` = 0 whenever `nxt_full` = 1.

## Timing
- Reset values: `pdm_clk` 0, `pdm_out` 0, `in_ready` 0, `underrun` 0, and all counters and state 0.
- First `clk` edge after reset release: `in_ready` becomes 1.
- First fall event: `clk` edge number CLK_DIV/2 after release. `pdm_clk` is already 0, and the first modulator bit is produced.
- First rise event: edge number CLK_DIV.
- `pdm_out` changes only on fall-event edges. It is stable for CLK_DIV `clk` cycles, centred on the `pdm_clk` rising edge.
- Accept-to-modulate latency: the sample is loaded at the next boundary.
  - If the buffer is empty, it is modulated starting from the first fall event after the current sample period ends.
  - Worst case OSR×CLK_DIV `clk` cycles.
- Throughput: one sample per OSR×CLK_DIV `clk` cycles. Back-to-back accepts are blocked until the buffered sample is consumed.
- Reset mid-operation: all state clears immediately (asynchronous). Any buffered sample is lost. No `underrun` pulse is generated by reset itself.

## Test plan
All scenarios use CLK_DIV=4, OSR=8, DATA_W=8 unless stated.
1. **Idle after reset.** Drive no input. Required:
   - `pdm_clk` period is 4 `clk` cycles.
   - `pdm_out` = 0,1,0,1,… from the first fall event.
   - `underrun` pulses on every 8th fall event.
2. **Sample 64.** Accept 64, so u=192. Required:
   - Once loaded, starting from `acc`=0, the bits repeat 0,1,1,1.
   - Over 8 bits, 6 are ones.
   - No `underrun` at that boundary.
3. **Extremes.** Feed 127 then -128, each accepted before its boundary. Required:
   - Sample 127: 8 ones in its period, or 7 depending on carry-over from `acc`.
   - Sample -128: 8 zeros with `acc` unchanged.
4. **Handshake.** Hold `in_valid`=1 with incrementing data. Required:
   - Exactly one accept per 32 `clk` cycles (8 bits × 4 `clk`).
   - `in_ready` is low between accepts.
   - No sample is skipped or duplicated.
5. **Reset mid-sample.** Assert `reset_n`=0 asynchronously while `nxt_full`=1. Required:
   - All outputs are 0 in the same cycle.
   - After release, the idle pattern of scenario 1 resumes.
   - The buffered sample is never emitted.
6. **Loopback.** Use default parameters. Feed a constant 64 into the PDM capture chain sampling `pdm_clk` rising edges. Required: the decimated output settles to a constant positive value.
